// File: rtl/mmio_tx_pkg.sv
// Shared constants for the MMIO transmit FIFO: register word offsets
// (relative to the window base) and STATUS bit positions.
package mmio_tx_pkg;

  localparam int unsigned TXDATA_OFS = 0;
  localparam int unsigned STATUS_OFS = 1;
  localparam int unsigned OVFCNT_OFS = 2;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 8;

  localparam int unsigned OVFCNT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with simultaneous push/pop.
// Ports: clk, resetn (async active-low), push/push_data, pop,
//        head_data (0 when empty), count, full, empty.
// A push into a full FIFO is taken only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero when empty so stale storage never leaks out.
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy state; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_tx_fifo.sv
// Memory-mapped byte transmit FIFO with a 3-word register window.
// Ports: clk, resetn (async active-low); core bus address/wdata/we with
//        combinational rdata/hit; byte sink tx_valid/tx_data/tx_ready.
// Registers: +0 TXDATA (write pushes), +4 STATUS, +8 OVFCNT.
// Optional feature macro: MMIO_TX_OVFCNT_EN adds a 16-bit saturating
// dropped-push counter at +8; without it +8 reads 0.
module mmio_tx_fifo
  import mmio_tx_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFF0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  logic [29:0]   word;
  logic [29:0]   diff;
  logic [1:0]    ofs;
  logic          push_req;
  logic          drop;
  logic          ovf_clr;
  logic          overflow;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   status;
  logic [31:0]   ovfcnt_rd;
  logic          unused_bits;

  // Window decode on word address; byte offset bits are don't-care.
  assign word = address[31:2];
  assign diff = word - BASE_WORD;
  assign hit  = (word >= BASE_WORD) && (diff <= 30'd2);
  assign ofs  = diff[1:0];

  assign push_req = we && hit && (ofs == 2'(TXDATA_OFS));
  assign ovf_clr  = we && hit && (ofs == 2'(STATUS_OFS)) && wdata[ST_OVF_BIT];
  // Full FIFO is never empty, so tx_ready alone decides whether a pop frees a slot.
  assign drop     = push_req && full && !tx_ready;

  assign unused_bits = ^{wdata[31:8], address[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_req),
    .push_data (wdata[7:0]),
    .pop       (tx_ready),
    .head_data (tx_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign tx_valid = !empty;

  // Sticky overflow flag; set and clear are on different addresses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef MMIO_TX_OVFCNT_EN
  logic [OVFCNT_W-1:0] ovf_cnt;
  logic                cnt_clr;

  assign cnt_clr = we && hit && (ofs == 2'(OVFCNT_OFS));

  // Saturating count of dropped pushes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVFCNT_W'(1);
    end
  end

  assign ovfcnt_rd = 32'(ovf_cnt);
`else
  assign ovfcnt_rd = '0;
`endif

  // STATUS word assembly.
  always_comb begin
    status                               = '0;
    status[ST_EMPTY_BIT]                 = empty;
    status[ST_FULL_BIT]                  = full;
    status[ST_OVF_BIT]                   = overflow;
    status[ST_COUNT_LSB +: ST_COUNT_W]   = ST_COUNT_W'(count);
  end

  // Register read mux; misses and TXDATA read as zero.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (ofs)
        2'(STATUS_OFS): rdata = status;
        2'(OVFCNT_OFS): rdata = ovfcnt_rd;
        default:        rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Self-checking bench for mmio_tx_fifo: a byte scoreboard fed by accepted
// writes and drained by sink handshakes, plus scenario tasks with inline checks.
module tb_mmio_tx_fifo;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] TX_A = 32'hFF0;
  localparam logic [31:0] ST_A = 32'hFF4;
  localparam logic [31:0] OC_A = 32'hFF8;

  logic        clk;
  logic        resetn;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  int         m_ovfcnt = 0;

  mmio_tx_fifo #(.DEPTH(DEPTH), .BASE_ADDR(32'hFF0)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .address  (address),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .hit      (hit),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset empties the model along with the DUT.
  always @(negedge resetn) begin
    q.delete();
    m_ovf    = 1'b0;
    m_ovfcnt = 0;
  end

  // Scoreboard: sample bus/sink half a cycle before the edge that acts on them.
  always @(negedge clk) begin : monitor
    bit do_pop;
    if (resetn) begin
      do_pop = tx_ready && (q.size() > 0);
      checks++;
      if (tx_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL tx_valid: got %b expected %b", tx_valid, q.size() != 0);
      end
      if (do_pop) begin
        checks++;
        if (tx_data !== q[0]) begin
          errors++;
          $display("FAIL tx_data order: got %02h expected %02h", tx_data, q[0]);
        end
        void'(q.pop_front());
      end
      if (we && address[31:2] == TX_A[31:2]) begin
        if (q.size() < DEPTH) q.push_back(wdata[7:0]);
        else begin
          m_ovf = 1'b1;
          if (m_ovfcnt < 65535) m_ovfcnt++;
        end
      end
      if (we && address[31:2] == ST_A[31:2] && wdata[2]) m_ovf = 1'b0;
      if (we && address[31:2] == OC_A[31:2]) m_ovfcnt = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (q.size() == 0);
    s[1] = (q.size() == DEPTH);
    s[2] = m_ovf;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  function automatic logic [31:0] model_ovfcnt();
`ifdef MMIO_TX_OVFCNT_EN
    return 32'(m_ovfcnt);
`else
    return 32'h0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    wdata   = d;
    we      = 1'b1;
    step();
    we      = 1'b0;
    address = ST_A;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = rdata;
  endtask

  task automatic drain();
    int n;
    n = 0;
    tx_ready = 1'b1;
    while (q.size() > 0 && n < 40) begin
      step();
      n++;
    end
    tx_ready = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes left, expected 0", q.size());
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: got %b expected 0", tx_valid);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    resetn = 1'b0; we = 1'b0; wdata = '0; tx_ready = 1'b0;
    rd(ST_A, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL reset_status: got %08h expected 00000001", v); end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b expected 1", hit); end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx: got valid %b data %02h expected 0/00", tx_valid, tx_data);
    end
    rd(32'h0, v);
    checks++;
    if (hit !== 1'b0 || v !== 32'h0) begin
      errors++; $display("FAIL miss_decode: got hit %b rdata %08h expected 0/0", hit, v);
    end
    #20;
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] v;
    tx_ready = 1'b0;
    wr(TX_A, 32'h41); wr(TX_A, 32'h42); wr(TX_A, 32'h43);
    rd(ST_A, v);
    checks++;
    if (v !== 32'h300) begin errors++; $display("FAIL basic_status3: got %08h expected 00000300", v); end
    tx_ready = 1'b1;
    #1;
    checks++;
    if (tx_data !== 8'h41) begin errors++; $display("FAIL basic_b0: got %02h expected 41", tx_data); end
    step();
    checks++;
    if (tx_data !== 8'h42) begin errors++; $display("FAIL basic_b1: got %02h expected 42", tx_data); end
    step();
    checks++;
    if (tx_data !== 8'h43) begin errors++; $display("FAIL basic_b2: got %02h expected 43", tx_data); end
    step();
    tx_ready = 1'b0;
    rd(ST_A, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL basic_empty: got %08h expected 00000001", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(TX_A, 32'(8'h50 + i));
    rd(ST_A, v);
    checks++;
    if (v !== 32'h806) begin errors++; $display("FAIL ovf_status: got %08h expected 00000806", v); end
    rd(OC_A, v);
    checks++;
    if (v !== model_ovfcnt()) begin errors++; $display("FAIL ovf_cnt1: got %08h expected %08h", v, model_ovfcnt()); end
    wr(ST_A, 32'h4);
    rd(ST_A, v);
    checks++;
    if (v !== 32'h802) begin errors++; $display("FAIL ovf_clear: got %08h expected 00000802", v); end
    drain();
  endtask

  task automatic test_full_pushpop();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(TX_A, 32'(8'h60 + i));
    address = TX_A; wdata = 32'h99; we = 1'b1; tx_ready = 1'b1;
    step();
    we = 1'b0; tx_ready = 1'b0;
    rd(ST_A, v);
    checks++;
    if (v !== 32'h802) begin errors++; $display("FAIL full_pushpop: got %08h expected 00000802", v); end
    drain();
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(TX_A, 32'(8'h70 + i));
    drain();
    for (int i = 0; i < 6; i++) wr(TX_A, 32'(8'h80 + i));
    rd(ST_A, v);
    checks++;
    if (v !== model_status()) begin errors++; $display("FAIL wrap_status: got %08h expected %08h", v, model_status()); end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(TX_A, 32'(8'h90 + i));
    tx_ready = 1'b1;
    step(); step();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_mid: got valid %b data %02h expected 0/00", tx_valid, tx_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    tx_ready = 1'b0;
    step();
    rd(ST_A, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL reset_mid_status: got %08h expected 00000001", v); end
  endtask

  task automatic test_ovfcnt();
    logic [31:0] v;
    tx_ready = 1'b0;
    wr(OC_A, 32'h0);
    for (int i = 0; i < 11; i++) wr(TX_A, 32'(8'hA0 + i));
    rd(OC_A, v);
    checks++;
`ifdef MMIO_TX_OVFCNT_EN
    if (v !== 32'h3) begin errors++; $display("FAIL ovfcnt3: got %08h expected 00000003", v); end
`else
    if (v !== 32'h0) begin errors++; $display("FAIL ovfcnt_off: got %08h expected 00000000", v); end
`endif
    rd(ST_A, v);
    checks++;
    if (v !== 32'h806) begin errors++; $display("FAIL ovfcnt_status: got %08h expected 00000806", v); end
    wr(OC_A, 32'h1234);
    rd(OC_A, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL ovfcnt_clear: got %08h expected 00000000", v); end
    wr(ST_A, 32'h4);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      address = TX_A; wdata = 32'(8'hC0 + i); we = 1'b1;
      step();
    end
    we = 1'b0;
    rd(ST_A, v);
    checks++;
    if (v !== model_status()) begin errors++; $display("FAIL b2b_status: got %08h expected %08h", v, model_status()); end
    drain();
  endtask

  initial begin
    address = ST_A;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_wrap();
    test_reset_mid();
    test_ovfcnt();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_tx_fifo.md
# mmio_tx_fifo

Memory-mapped transmit FIFO on the core's data bus, decoded in parallel with the main memory. Stores of bytes to its data register are buffered and drained to a byte-wide valid/ready sink, such as a console model or UART shifter. A status register lets firmware poll occupancy and a sticky overflow flag. The top level muxes `rdata` onto the core's `data_in` whenever `hit` is high.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of two, 2..128.
- `BASE_ADDR`, 32'hFF0: word-aligned base of the 3-word register window.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `address`  in  32  — core bus address.
- `wdata`  in  32  — core store data (core `data_out`).
- `we`  in  1  — core write enable.
- `rdata`  out  32  — register read data, combinational from `address`.
- `hit`  out  1  — `address` is in the window `BASE_ADDR`..`BASE_ADDR+8`.
- `tx_valid`  out  1  — FIFO non-empty.
- `tx_data`  out  8  — head byte.
- `tx_ready`  in  1  — sink accepts the head byte.

## Operation
- Register map. Offsets use `address[3:2]`; `address[1:0]` is ignored.
  - +0 TXDATA
    - Write pushes `wdata[7:0]`.
    - Read returns 0.
  - +4 STATUS, read layout:
    - [0] empty, [1] full, [2] overflow.
    - [15:8] count, zero-extended.
    - All other bits 0.
  - +4 STATUS, write: `wdata[2]`=1 clears overflow. Other bits are ignored.
  - +8 OVFCNT: see Configuration.
- `hit` and `rdata` are purely combinational. A non-hit address gives `rdata`=0.
- Push condition: `we` && TXDATA hit at a rising edge.
  - The push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow is set to 1, and the FIFO is unchanged.
- Pop condition: `tx_valid && tx_ready` at a rising edge.
  - The head advances and count decrements.
  - `tx_ready` while empty has no effect.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- An overflow set and a STATUS clear cannot coincide, since they are different addresses.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- `tx_data` is stable while `tx_valid` is high and `tx_ready` is low. This is the standard valid/ready contract.

## Timing
- Reset values (asynchronous, while `resetn`=0):
  - Pointers 0, count 0, overflow 0, OVFCNT 0.
  - Outputs: `tx_valid`=0 and `tx_data`=0.
  - `hit`/`rdata` follow `address` even in reset.
- Push-to-`tx_valid` latency: 1 cycle. A byte written at edge N is visible with `tx_valid`=1 after edge N.
- STATUS reflects all pushes and pops from prior edges. It is the same cycle as the core's read, with no read latency.
- Throughput: 1 push and 1 pop per cycle, sustained.
- Reset mid-transfer: all contents are discarded. `tx_valid` drops asynchronously.

## Configuration
- `MMIO_TX_OVFCNT_EN` defined:
  - A 16-bit saturating counter increments on each dropped push.
  - Read at +8, zero-extended.
  - A write at +8 of any value clears it.
- Not defined:
  - +8 reads 0, and writes to it are ignored.
  - No counter flops are synthesized.
  - `hit` still covers +8.

## Structure
- Package `mmio_tx_pkg`:
  - Register offset constants (`TXDATA_OFS`, `STATUS_OFS`, `OVFCNT_OFS`).
  - STATUS bit-index constants.
- Sub-module `sync_fifo`: parameterised width/depth circular buffer with push/pop/count/full/empty.
- `mmio_tx_fifo` itself holds only decode, the overflow logic and the register mux.

## Test plan
- Reset, then read 0xFF4 → `rdata`=0x00000001 (empty). `tx_valid`=0, `hit`=1. Reading 0x000 gives `hit`=0.
- Write 0x41, 0x42, 0x43 to 0xFF0 with `tx_ready`=0 → STATUS=0x00000300. Then raise `tx_ready` → sink receives 0x41, 0x42, 0x43 on consecutive cycles, and STATUS returns to 0x00000001.
- With `tx_ready`=0, write 9 bytes (DEPTH=8) → STATUS=0x00000806 (count 8, full, overflow). Drained bytes are the first 8 only. Write 0x4 to 0xFF4 → overflow clears.
- Full FIFO, with a push and `tx_ready`=1 in the same cycle → push is accepted, count stays 8, overflow stays 0.
- Fill 5, drain 5, then write 6 more → correct FIFO order across the pointer wrap. Assert `resetn`=0 mid-drain → `tx_valid` is 0 immediately and STATUS=0x1 after release.
- With `MMIO_TX_OVFCNT_EN`: 3 dropped pushes → 0xFF8 reads 3, and a write to 0xFF8 clears it. Without the macro, 0xFF8 reads 0.
